filter_bank_seq: RTL and testbench
==================================

FILTER_BANK_SEQ -- requirements
Module: filter_bank_seq

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of filter channels driven and sampled.
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-channel signed event counter.
REQ-003 SHALL have parameter PH_W, default 8, width of phase-length and dead-time settings.
REQ-004 SHALL have port wb_clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  run enable for phase generator and counting.
REQ-007 SHALL have port half_cyc  input  PH_W  clock cycles per phi1 or phi2 high phase; 0 treated as 1.
REQ-008 SHALL have port dead_cyc  input  PH_W  non-overlap cycles after each phase; 0 allowed.
REQ-009 SHALL have port win_len  input  16  full phi periods per counting window; 0 treated as 1.
REQ-010 SHALL have port compout  input  N_CH  per-channel comparator outputs, asynchronous to wb_clk_i.
REQ-011 SHALL have port pol  input  N_CH  per-channel polarity, asynchronous to wb_clk_i.
REQ-012 SHALL have port phi1, phi2, phi1b, phi2b  output  1 each  shared two-phase filter clocks and complements.
REQ-013 SHALL have port out_data  output  N_CH*CNT_W  window snapshot, channel 0 in LSBs, two's complement.
REQ-014 SHALL have port out_valid  output  1  snapshot available; out_ready  input  1  consumer accept.
REQ-015 SHALL have port overrun  output  1  sticky lost-snapshot flag; clr_ovr  input  1  synchronous clear.

Function
REQ-016 SHALL sequence FSM IDLE -> PHI1 (half_cyc cycles) -> DEAD1 (dead_cyc cycles) -> PHI2 (half_cyc) -> DEAD2 (dead_cyc) -> PHI1; DEAD states skipped when dead_cyc=0.
REQ-017 SHALL drive phi1 high only in PHI1 and phi2 high only in PHI2, all four outputs registered; phi1b=~phi1, phi2b=~phi2 in the same cycle.
REQ-018 SHALL never assert phi1 and phi2 in the same cycle, including across setting changes.
REQ-019 SHALL latch half_cyc/dead_cyc at entry to each state; mid-state changes take effect at the next state.
REQ-020 SHALL leave IDLE for PHI1 the cycle after en is sampled high; on en low SHALL go to IDLE next cycle from any state, phi outputs low, counters and window count cleared, pending snapshot kept.
REQ-021 SHALL pass compout and pol through 2-flop synchronizers per channel.
REQ-022 SHALL sample synchronized compout/pol once per period, in the last PHI2 cycle.
REQ-023 SHALL per sample: compout=1,pol=1 -> counter+1; compout=1,pol=0 -> counter-1; compout=0 -> hold.
REQ-024 SHALL end a window at the win_len-th sample; that sample is included, then all counters reset to 0 in the next cycle.
REQ-025 SHALL at window end load out_data and set out_valid if out_valid is low, or out_valid and out_ready are both high in that cycle.
REQ-026 SHALL otherwise drop the new snapshot, keep out_data unchanged, and set overrun.
REQ-027 SHALL clear out_valid on out_valid&&out_ready with no concurrent load; out_data SHALL be stable while out_valid is high.
REQ-028 SHALL let overrun set take priority over clr_ovr in the same cycle.

Reset
REQ-029 SHALL on wb_rst_i asynchronously force IDLE, phi1=phi2=0, phi1b=phi2b=1, out_valid=0, overrun=0, out_data=0, counters, window count and synchronizers 0.
REQ-030 SHALL resume only via REQ-020 after reset release, even if en is held high throughout reset.

Configuration
REQ-031 SHALL honour macro FILTER_BANK_SEQ_SATURATE_EN: defined -> counters clamp at +2^(CNT_W-1)-1 and -2^(CNT_W-1); undefined -> counters wrap modulo 2^CNT_W.

Verification
REQ-032 SHALL check half_cyc=3, dead_cyc=2, en=1: phi1 high 3 cycles, both low 2, phi2 high 3, both low 2, period 10; no overlap.
REQ-033 SHALL check win_len=5, ch0 compout=1/pol=1, ch1 compout=1/pol=0, others 0: out_data ch0=5, ch1=-5 (0xFB), ch2=ch3=0, out_valid=1.
REQ-034 SHALL check CNT_W=4, win_len=10, ch0 compout=1/pol=1: +7 with macro, -6 (0xA) without.
REQ-035 SHALL check out_ready=0 over two windows: second snapshot dropped, first retained, overrun=1; clr_ovr clears it.
REQ-036 SHALL check wb_rst_i pulsed mid-PHI2: phi outputs reset the same cycle without waiting for a clock; after release with en=1, PHI1 starts after one cycle.
REQ-037 SHALL check en dropped mid-window: phi outputs low next cycle; after re-enable, full win_len samples precede the next out_valid.

Source files
------------

// File: rtl/filter_bank_seq.sv
`default_nettype none
// ============================================================================
// Module   : filter_bank_seq
// Brief    : Two-phase non-overlapping clock generator for a switched-capacitor
//            filter bank, with per-channel signed event counters sampled once
//            per phi period and windowed snapshots handed out over a
//            valid/ready port with a sticky overrun flag.
// Config   : FILTER_BANK_SEQ_SATURATE_EN -- defined: counters clamp at the
//            signed limits; undefined: counters wrap modulo 2^CNT_W.
// Revision : 1.0 - initial release
// ============================================================================
module filter_bank_seq #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int PH_W  = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    en,
  input  logic [PH_W-1:0]         half_cyc,
  input  logic [PH_W-1:0]         dead_cyc,
  input  logic [15:0]             win_len,
  input  logic [N_CH-1:0]         compout,
  input  logic [N_CH-1:0]         pol,
  output logic                    phi1,
  output logic                    phi2,
  output logic                    phi1b,
  output logic                    phi2b,
  output logic [N_CH*CNT_W-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  input  logic                    clr_ovr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PHI1  = 3'd1,
    S_DEAD1 = 3'd2,
    S_PHI2  = 3'd3,
    S_DEAD2 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] c_cnt_min = {1'b1, {(CNT_W-1){1'b0}}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PH_W-1:0]       r_cnt;
  logic [PH_W-1:0]       r_lim;
  logic [PH_W-1:0]       w_lim_nxt;
  logic [PH_W-1:0]       w_half_eff;
  logic                  w_last;
  logic                  w_enter;
  logic                  w_sample;

  logic [N_CH-1:0]       r_cmp_s1, r_cmp_s2;
  logic [N_CH-1:0]       r_pol_s1, r_pol_s2;

  logic [15:0]           w_win_eff;
  logic [15:0]           r_win;
  logic                  w_win_end;
  logic                  r_wend;
  logic                  w_load;
  logic [N_CH*CNT_W-1:0] w_cnt_flat;

  assign w_half_eff = (half_cyc == '0) ? PH_W'(1) : half_cyc;
  assign w_last     = (r_cnt == r_lim);
  assign w_enter    = (w_state_nxt != r_state);
  // One sample per period, taken in the final PHI2 cycle.
  assign w_sample   = en && (r_state == S_PHI2) && w_last;
  assign w_win_eff  = (win_len == '0) ? 16'd1 : win_len;
  assign w_win_end  = w_sample && (({1'b0, r_win} + 17'd1) >= {1'b0, w_win_eff});
  assign w_load     = r_wend && (!out_valid || out_ready);

  // Next-state selection and length of the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_PHI1;
        S_PHI1:  if (w_last) w_state_nxt = (dead_cyc == '0) ? S_PHI2 : S_DEAD1;
        S_DEAD1: if (w_last) w_state_nxt = S_PHI2;
        S_PHI2:  if (w_last) w_state_nxt = (dead_cyc == '0) ? S_PHI1 : S_DEAD2;
        S_DEAD2: if (w_last) w_state_nxt = S_PHI1;
        default: w_state_nxt = S_IDLE;
      endcase
    end
    // Settings are latched only on entry, so a DEAD state is never entered
    // with a zero length.
    w_lim_nxt = ((w_state_nxt == S_DEAD1) || (w_state_nxt == S_DEAD2)) ?
                (dead_cyc - PH_W'(1)) : (w_half_eff - PH_W'(1));
  end

  // State register, in-state cycle counter and registered phase outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lim   <= '0;
      phi1    <= 1'b0;
      phi2    <= 1'b0;
      phi1b   <= 1'b1;
      phi2b   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter) begin
        r_cnt <= '0;
        r_lim <= w_lim_nxt;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + PH_W'(1);
      end
      // Decoding from the next state keeps the outputs aligned with the state.
      phi1  <= (w_state_nxt == S_PHI1);
      phi2  <= (w_state_nxt == S_PHI2);
      phi1b <= (w_state_nxt != S_PHI1);
      phi2b <= (w_state_nxt != S_PHI2);
    end
  end

  // Two-flop synchronizers for the asynchronous comparator and polarity lines.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cmp_s1 <= '0;
      r_cmp_s2 <= '0;
      r_pol_s1 <= '0;
      r_pol_s2 <= '0;
    end else begin
      r_cmp_s1 <= compout;
      r_cmp_s2 <= r_cmp_s1;
      r_pol_s1 <= pol;
      r_pol_s2 <= r_pol_s1;
    end
  end

  // Window sample count; the window-end flag lets counters include the last
  // sample before the snapshot is taken and they are cleared.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_win  <= '0;
      r_wend <= 1'b0;
    end else begin
      r_wend <= w_win_end;
      if (!en || w_win_end) begin
        r_win <= '0;
      end else if (w_sample) begin
        r_win <= r_win + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_ev;
    logic [CNT_W-1:0] w_ev_upd;

    // Up/down step for this channel, direction chosen by polarity.
    always_comb begin
      w_ev_upd = r_ev;
      if (r_cmp_s2[g]) begin
        if (r_pol_s2[g]) begin
`ifdef FILTER_BANK_SEQ_SATURATE_EN
          if (r_ev != c_cnt_max) w_ev_upd = r_ev + CNT_W'(1);
`else
          w_ev_upd = r_ev + CNT_W'(1);
`endif
        end else begin
`ifdef FILTER_BANK_SEQ_SATURATE_EN
          if (r_ev != c_cnt_min) w_ev_upd = r_ev - CNT_W'(1);
`else
          w_ev_upd = r_ev - CNT_W'(1);
`endif
        end
      end
    end

    // Counter register: cleared when disabled or just after a window closes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        r_ev <= '0;
      end else if (!en || r_wend) begin
        r_ev <= '0;
      end else if (w_sample) begin
        r_ev <= w_ev_upd;
      end
    end

    assign w_cnt_flat[g*CNT_W +: CNT_W] = r_ev;
  end

  // Snapshot hand-off; overrun is sticky and a new set beats clr_ovr.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        out_data  <= w_cnt_flat;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (r_wend && !w_load) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_filter_bank_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_bank_seq
// Brief    : Self-checking bench for filter_bank_seq; phase waveform, window
//            timing and snapshot contents come from a period/arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_bank_seq;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int PH_W  = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0;
  logic                  out_ready = 1'b0;
  logic                  clr_ovr = 1'b0;
  logic [PH_W-1:0]       half_cyc = 8'd3;
  logic [PH_W-1:0]       dead_cyc = 8'd2;
  logic [15:0]           win_len = 16'd1;
  logic [N_CH-1:0]       compout = '0;
  logic [N_CH-1:0]       pol = '0;

  logic                  phi1, phi2, phi1b, phi2b, out_valid, overrun;
  logic [N_CH*CNT_W-1:0] out_data;
  logic                  s_phi1, s_phi2, s_phi1b, s_phi2b, s_valid, s_overrun;
  logic [3:0]            s_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_bank_seq #(.N_CH(N_CH), .CNT_W(CNT_W), .PH_W(PH_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .half_cyc(half_cyc),
    .dead_cyc(dead_cyc), .win_len(win_len), .compout(compout), .pol(pol),
    .phi1(phi1), .phi2(phi2), .phi1b(phi1b), .phi2b(phi2b),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .clr_ovr(clr_ovr)
  );

  // Narrow-counter instance for the wrap/clamp behaviour.
  filter_bank_seq #(.N_CH(1), .CNT_W(4), .PH_W(PH_W)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .half_cyc(half_cyc),
    .dead_cyc(dead_cyc), .win_len(win_len), .compout(compout[0:0]), .pol(pol[0:0]),
    .phi1(s_phi1), .phi2(s_phi2), .phi1b(s_phi1b), .phi2b(s_phi2b),
    .out_data(s_data), .out_valid(s_valid), .out_ready(out_ready),
    .overrun(s_overrun), .clr_ovr(clr_ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Final value of a w-bit counter after v net unit steps from zero.
  function automatic int model_cnt(input int v, input int w);
    int r;
    r = v;
`ifdef FILTER_BANK_SEQ_SATURATE_EN
    if (r > (1 << (w - 1)) - 1) r = (1 << (w - 1)) - 1;
    if (r < -(1 << (w - 1)))    r = -(1 << (w - 1));
`endif
    return r & ((1 << w) - 1);
  endfunction

  // Enable the generator and follow two windows with out_ready low, then
  // disable, clear overrun and consume the retained snapshot.
  task automatic run_pass(input bit do_rst, input bit chk4);
    int he, de, per, we, v1, v2, pos, v, t;
    logic e1, e2;
    logic [31:0] ed;
    if (do_rst) begin
      @(negedge clk); rst = 1'b1; en = 1'b0;
      @(negedge clk); rst = 1'b0;
    end
    en = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    he  = (half_cyc == 0) ? 1 : int'(half_cyc);
    de  = int'(dead_cyc);
    we  = (win_len == 0) ? 1 : int'(win_len);
    per = 2 * he + 2 * de;
    v1  = (we - 1) * per + 2 * he + de + 2;
    v2  = (2 * we - 1) * per + 2 * he + de + 2;
    ed  = '0;
    for (int c = 0; c < N_CH; c++) begin
      v = compout[c] ? (pol[c] ? we : -we) : 0;
      t = model_cnt(v, CNT_W);
      ed[c*CNT_W +: CNT_W] = t[CNT_W-1:0];
    end
    en = 1'b1;
    for (int n = 1; n <= v2 + 1; n++) begin
      @(posedge clk); #1;
      pos = (n - 1) % per;
      e1 = (pos < he);
      e2 = (pos >= he + de) && (pos < 2 * he + de);
      check("phi", {phi1, phi2, phi1b, phi2b}, {e1, e2, ~e1, ~e2});
      check("valid", out_valid, (n >= v1) ? 1 : 0);
      check("overrun", overrun, (n >= v2) ? 1 : 0);
      if (n == v1) begin
        check("data", out_data, ed);
        if (chk4) begin
          t = model_cnt(compout[0] ? (pol[0] ? we : -we) : 0, 4);
          check("valid4", s_valid, 1);
          check("data4", s_data, t[3:0]);
        end
      end
    end
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    check("phi_off", {phi1, phi2, phi1b, phi2b}, 4'b0011);
    check("data_kept", out_data, ed);
    @(negedge clk); clr_ovr = 1'b1;
    @(posedge clk); #1;
    check("ovr_clr", overrun, 0);
    @(negedge clk); clr_ovr = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_clr", out_valid, 0);
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_phi", {phi1, phi2, phi1b, phi2b}, 4'b0011);
    check("rst_valid", out_valid, 0);
    check("rst_ovr", overrun, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;

    // 3/2 phase timing with a 5-sample window, one up and one down channel.
    half_cyc = 8'd3; dead_cyc = 8'd2; win_len = 16'd5;
    compout = 4'b0011; pol = 4'b0001;
    run_pass(1'b1, 1'b0);

    // Ten-sample window on the narrow instance.
    half_cyc = 8'd1; dead_cyc = 8'd0; win_len = 16'd10;
    compout = 4'b0001; pol = 4'b0001;
    run_pass(1'b1, 1'b1);

    // Drop enable mid-window, then re-enable for a full window.
    half_cyc = 8'd2; dead_cyc = 8'd1; win_len = 16'd3;
    compout = 4'b1010; pol = 4'b1000;
    @(negedge clk); en = 1'b1;
    repeat (8) @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    check("en_drop_phi", {phi1, phi2, phi1b, phi2b}, 4'b0011);
    check("en_drop_valid", out_valid, 0);
    run_pass(1'b0, 1'b0);

    // Randomised settings and inputs, including zero half/window settings.
    for (int r = 0; r < 12; r++) begin
      half_cyc = PH_W'($urandom_range(0, 4));
      dead_cyc = PH_W'($urandom_range(0, 3));
      win_len  = 16'($urandom_range(0, 4));
      compout  = N_CH'($urandom);
      pol      = N_CH'($urandom);
      run_pass(1'b1, 1'b0);
    end

    // Asynchronous reset in the middle of PHI2.
    half_cyc = 8'd3; dead_cyc = 8'd2; win_len = 16'd2;
    @(negedge clk); en = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (phi2) seen = 1'b1;
    end
    if (!seen) check("phi2_wait", 0, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_phi", {phi1, phi2, phi1b, phi2b}, 4'b0011);
    check("arst_valid", out_valid, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_phi1", {phi1, phi2, phi1b, phi2b}, 4'b1001);
    @(negedge clk); en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
